uart_rx_sipo: RTL and testbench



---
 rtl/uart_pkg.sv | 17 +
 rtl/sync_2ff.sv | 23 ++
 rtl/uart_rx_sipo.sv | 163 ++++++++++++++++
 tb/tb_uart_rx_sipo.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and defaults for the UART receive path
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        DATA    = 3'd2,
        PARITY  = 3'd3,
        STOP    = 3'd4,
        CLEANUP = 3'd5
    } state_t;

    localparam int   DEFAULT_CLKS_PER_BIT = 16;
    localparam int   DEFAULT_DATA_BITS    = 8;
    localparam logic IDLE_LEVEL           = 1'b1;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - generic two-flop synchroniser for asynchronous inputs
module sync_2ff #(
    parameter logic INIT = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= INIT;
            q    <= INIT;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_sipo.sv
// rtl/uart_rx_sipo.sv - UART receiver, mid-bit sampling; UART_RX_PARITY_EN adds even parity
module uart_rx_sipo
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int DATA_BITS    = DEFAULT_DATA_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 serial_in,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 busy
`ifdef UART_RX_PARITY_EN
    ,
    output logic                 parity_err
`endif
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS) + 1;
    localparam logic [CW-1:0] HALF_M1  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1  = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    state_t                 state_q, state_d;
    logic                   s_rx;
    logic [CW-1:0]          clk_cnt;
    logic [BW-1:0]          bit_idx;
    logic [DATA_BITS-1:0]   shreg;
    logic                   brk_q;
    logic                   cnt_clr, bit_clr, bit_inc, shift_en, stop_done;
`ifdef UART_RX_PARITY_EN
    logic                   par_done, par_bad;
`endif

    sync_2ff #(.INIT(IDLE_LEVEL)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (serial_in),
        .q   (s_rx)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        cnt_clr   = 1'b0;
        bit_clr   = 1'b0;
        bit_inc   = 1'b0;
        shift_en  = 1'b0;
        stop_done = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_done  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                cnt_clr = 1'b1;
                bit_clr = 1'b1;
                // After a break, wait for the line to go high before arming again
                if (s_rx != IDLE_LEVEL && !brk_q) state_d = START;
            end
            START: begin
                if (clk_cnt == HALF_M1) begin
                    cnt_clr = 1'b1;
                    bit_clr = 1'b1;
                    state_d = (s_rx == IDLE_LEVEL) ? IDLE : DATA;
                end
            end
            DATA: begin
                if (clk_cnt == FULL_M1) begin
                    cnt_clr  = 1'b1;
                    shift_en = 1'b1;
                    bit_inc  = 1'b1;
                    if (bit_idx == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (clk_cnt == FULL_M1) begin
                    cnt_clr  = 1'b1;
                    par_done = 1'b1;
                    state_d  = STOP;
                end
            end
`endif
            STOP: begin
                if (clk_cnt == FULL_M1) begin
                    cnt_clr   = 1'b1;
                    stop_done = 1'b1;
                    state_d   = CLEANUP;
                end
            end
            CLEANUP: begin
                cnt_clr = 1'b1;
                bit_clr = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            clk_cnt   <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            brk_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad    <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            clk_cnt   <= cnt_clr ? '0 : clk_cnt + 1'b1;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
            if (par_done) par_bad <= (s_rx != ^shreg);
`endif
            if (bit_clr)      bit_idx <= '0;
            else if (bit_inc) bit_idx <= bit_idx + 1'b1;
            // LSB arrives first, so shifting right leaves it at bit 0
            if (shift_en) shreg <= {s_rx, shreg[DATA_BITS-1:1]};
            if (stop_done) begin
                if (s_rx == IDLE_LEVEL) begin
`ifdef UART_RX_PARITY_EN
                    if (par_bad) begin
                        parity_err <= 1'b1;
                    end else begin
                        rx_valid <= 1'b1;
                        rx_data  <= shreg;
                    end
`else
                    rx_valid <= 1'b1;
                    rx_data  <= shreg;
`endif
                end else begin
                    frame_err <= 1'b1;
                    brk_q     <= 1'b1;
                end
            end else if (brk_q && s_rx == IDLE_LEVEL) begin
                brk_q <= 1'b0;
            end
        end
    end

    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_sipo.sv
// tb/tb_uart_rx_sipo.sv - directed self-checking bench for uart_rx_sipo
module tb_uart_rx_sipo;

    logic       clk = 1'b0;
    logic       rst;
    logic       serial_in;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       busy;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
    int         npe = 0;
`endif

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int nv = 0, nfe = 0, nbusy = 0, nboth = 0;
    int v_last = 0, v_prev = 0;
    logic [7:0] d_last = 8'h00, d_prev = 8'h00;
    int stop_cyc = 0;
    int base_v, base_fe, base_busy, lat;

    uart_rx_sipo #(.CLKS_PER_BIT(16), .DATA_BITS(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .serial_in (serial_in),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .busy      (busy)
`ifdef UART_RX_PARITY_EN
        ,
        .parity_err(parity_err)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_valid) begin
            nv++;
            v_prev = v_last;
            v_last = cyc;
            d_prev = d_last;
            d_last = rx_data;
        end
        if (frame_err) nfe++;
        if (busy) nbusy++;
        if (rx_valid && frame_err) nboth++;
`ifdef UART_RX_PARITY_EN
        if (parity_err) npe++;
`endif
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        serial_in = b;
        repeat (16) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        serial_in = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        send_bit(^d);
`endif
        stop_cyc = cyc;
        send_bit(stop);
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic send_bad_parity(input logic [7:0] d);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(~^d);
        send_bit(1'b1);
    endtask
`endif

    initial begin
        rst = 1'b1;
        serial_in = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_rx_data", rx_data, 8'h00);
        chk("reset_rx_valid", rx_valid, 1'b0);
        chk("reset_frame_err", frame_err, 1'b0);
        chk("reset_busy", busy, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;
        idle(5);

        // clean 0x8F frame
        base_v = nv; base_fe = nfe;
        send_frame(8'h8F, 1'b1);
        idle(20);
        chk("8f_valid_cycles", nv - base_v, 1);
        chk("8f_data", rx_data, 8'h8F);
        chk("8f_pulse_data", d_last, 8'h8F);
        chk("8f_frame_err", nfe - base_fe, 0);
        chk("8f_busy_after", busy, 1'b0);
        lat = v_last - stop_cyc;
        chk("8f_latency_ok", (lat >= 1 && lat <= 11), 1'b1);

        // 3-cycle glitch
        base_v = nv; base_fe = nfe; base_busy = nbusy;
        serial_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        idle(30);
        chk("glitch_valid", nv - base_v, 0);
        chk("glitch_frame_err", nfe - base_fe, 0);
        chk("glitch_busy_short", ((nbusy - base_busy) >= 1 && (nbusy - base_busy) <= 10), 1'b1);
        chk("glitch_busy_after", busy, 1'b0);
        chk("glitch_data", rx_data, 8'h8F);

        // 0x55 with stop bit low, line held low afterwards
        base_v = nv; base_fe = nfe;
        send_frame(8'h55, 1'b0);
        serial_in = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        base_busy = nbusy;
        repeat (60) @(posedge clk);
        #1;
        chk("break_frame_err", nfe - base_fe, 1);
        chk("break_valid", nv - base_v, 0);
        chk("break_data_held", rx_data, 8'h8F);
        chk("break_no_restart", nbusy - base_busy, 0);
        chk("break_no_both", nboth, 0);
        idle(20);
        base_v = nv;
        send_frame(8'hC3, 1'b1);
        idle(20);
        chk("after_break_valid", nv - base_v, 1);
        chk("after_break_data", rx_data, 8'hC3);

        // back-to-back 0x00 then 0xFF
        base_v = nv; base_fe = nfe;
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        idle(20);
        chk("b2b_count", nv - base_v, 2);
        chk("b2b_first", d_prev, 8'h00);
        chk("b2b_second", d_last, 8'hFF);
        chk("b2b_spacing", v_last - v_prev, 160);
        chk("b2b_frame_err", nfe - base_fe, 0);

        // reset during 4th data bit of 0xA5
        base_v = nv; base_fe = nfe;
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        serial_in = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        serial_in = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_rx_data", rx_data, 8'h00);
        chk("midrst_rx_valid", rx_valid, 1'b0);
        chk("midrst_frame_err", frame_err, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;
        idle(200);
        chk("midrst_no_pulse", (nv - base_v) + (nfe - base_fe), 0);
        send_frame(8'h3C, 1'b1);
        idle(20);
        chk("post_rst_valid", nv - base_v, 1);
        chk("post_rst_data", rx_data, 8'h3C);

`ifdef UART_RX_PARITY_EN
        base_v = nv; base_fe = npe;
        send_frame(8'h07, 1'b1);
        idle(20);
        chk("par_ok_valid", nv - base_v, 1);
        chk("par_ok_data", rx_data, 8'h07);
        chk("par_ok_no_err", npe - base_fe, 0);
        base_v = nv; base_fe = npe;
        send_bad_parity(8'h07);
        idle(20);
        chk("par_bad_err", npe - base_fe, 1);
        chk("par_bad_no_valid", nv - base_v, 0);
        chk("par_bad_data_held", rx_data, 8'h07);
`endif

        chk("never_both", nboth, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
